// File: rtl/seq_alu_nbit_pkg.sv
// Shared constants for the sequential N-bit ALU: operation codes,
// FSM state encodings and the supported operand-width range.
package seq_alu_nbit_pkg;

  // Supported operand widths
  localparam int W_MIN = 4;
  localparam int W_MAX = 32;

  // Operation codes; 101..111 are illegal and ignored
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_DIV;
  endfunction

endpackage

// File: rtl/seq_alu_nbit_fadd_sub.sv
// W-bit adder/subtractor. With sub=1 it computes a + ~b + 1, so cout is
// the inverted borrow (1 means a >= b unsigned).
module fadd_sub_nbit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/seq_alu_nbit.sv
// Sequential ALU: single-cycle ADD/SUB/AND, W-cycle shift-add MUL and
// restoring DIV sharing one adder, one step counter and one 2W-bit
// working register. Results and flags change only when done pulses.
module seq_alu_nbit
  import seq_alu_nbit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result_hi,
  output logic [W-1:0] result_lo,
  output logic         zero_flag,
  output logic         sign_flag,
  output logic         carry_flag,
  output logic         dz_flag
);

  localparam logic [W-1:0] CNT_INIT = W'(W - 1);

  logic [1:0]   state;
  logic [W-1:0] cnt;
  logic [2:0]   op_r;
  logic [W-1:0] a_r, b_r;
  logic [W-1:0] work_hi, work_lo;

  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_sub, add_cout;
  logic [W-1:0] step_hi, step_lo;
  logic         div_ge;
  logic [W-1:0] fin_hi, fin_lo;
  logic         fin_c, fin_s, fin_dz;

  logic accept, needs_calc, last_step, load_res;

  assign accept     = (state == ST_IDLE) && start && op_legal(op);
  assign needs_calc = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
  assign last_step  = (state == ST_CALC) && (cnt == '0);
  assign load_res   = (accept && !needs_calc) || last_step;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  fadd_sub_nbit #(.W(W)) u_add (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Steer the shared adder: live operands in IDLE, MUL accumulate or DIV trial subtract in CALC
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    add_a   = a;
    add_b   = b;
    add_sub = (op == OP_SUB);
    if (state == ST_CALC) begin
      if (op_r == OP_MUL) begin
        add_a   = work_hi;
        add_b   = a_r;
        add_sub = 1'b0;
      end else begin
        add_a   = {work_hi[W-2:0], work_lo[W-1]};
        add_b   = b_r;
        add_sub = 1'b1;
      end
    end
  end

  // One MUL (LSB-first shift-add) or DIV (MSB-first restoring) step on the working register
  always_comb begin
    // The shifted remainder is W+1 bits; its dropped top bit alone guarantees it exceeds b
    div_ge  = work_hi[W-1] | add_cout;
    step_hi = '0;
    step_lo = '0;
    if (op_r == OP_MUL) begin
      if (work_lo[0]) begin
        step_hi = {add_cout, add_sum[W-1:1]};
        step_lo = {add_sum[0], work_lo[W-1:1]};
      end else begin
        step_hi = {1'b0, work_hi[W-1:1]};
        step_lo = {work_hi[0], work_lo[W-1:1]};
      end
    end else begin
      step_hi = div_ge ? add_sum : {work_hi[W-2:0], work_lo[W-1]};
      step_lo = {work_lo[W-2:0], div_ge};
    end
  end

  // Select the values published on completion; sign_flag is only meaningful for SUB
  always_comb begin
    fin_hi = '0;
    fin_lo = '0;
    fin_c  = 1'b0;
    fin_s  = 1'b0;
    fin_dz = 1'b0;
    if (state == ST_CALC) begin
      fin_hi = step_hi;
      fin_lo = step_lo;
      fin_c  = (op_r == OP_MUL) && (|step_hi);
    end else begin
      case (op)
        OP_ADD: begin
          fin_lo = add_sum;
          fin_c  = add_cout;
        end
        OP_SUB: begin
          fin_lo = add_sum;
          fin_c  = ~add_cout;
          fin_s  = ~add_cout;
        end
        OP_AND: fin_lo = a & b;
        OP_DIV: begin
          fin_lo = '1;
          fin_hi = a;
          fin_dz = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM and step counter
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state <= needs_calc ? ST_CALC : ST_DONE;
          cnt   <= CNT_INIT;
        end
        ST_CALC: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture on accepted start and working-register stepping during CALC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else if (accept) begin
      op_r    <= op;
      a_r     <= a;
      b_r     <= b;
      work_hi <= '0;
      work_lo <= (op == OP_MUL) ? b : a;
    end else if (state == ST_CALC) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
    end
  end

  // Publish results and flags only on completion so partial values never leak out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_hi  <= '0;
      result_lo  <= '0;
      zero_flag  <= 1'b0;
      sign_flag  <= 1'b0;
      carry_flag <= 1'b0;
      dz_flag    <= 1'b0;
    end else if (load_res) begin
      result_hi  <= fin_hi;
      result_lo  <= fin_lo;
      zero_flag  <= ~|{fin_hi, fin_lo};
      sign_flag  <= fin_s;
      carry_flag <= fin_c;
      dz_flag    <= fin_dz;
    end
  end

endmodule

// File: tb/tb_seq_alu_nbit.sv
// Scoreboard bench for seq_alu_nbit: directed W=8 vectors with hand-computed
// results, then W=4 and W=16 instances driven against a reference model.
module tb_seq_alu_nbit;
  import seq_alu_nbit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z, s, c, d;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start8, start4, start16;
  logic [2:0]  op8, op4, op16;
  logic [7:0]  a8, b8, hi8, lo8;
  logic [3:0]  a4, b4, hi4, lo4;
  logic [15:0] a16, b16, hi16, lo16;
  logic        busy8, done8, z8, s8, c8, d8;
  logic        busy4, done4, z4, s4, c4, d4;
  logic        busy16, done16, z16, s16, c16, d16;

  exp_t q8[$], q4[$], q16[$];

  seq_alu_nbit #(.W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_hi(hi8), .result_lo(lo8),
    .zero_flag(z8), .sign_flag(s8), .carry_flag(c8), .dz_flag(d8));

  seq_alu_nbit #(.W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result_hi(hi4), .result_lo(lo4),
    .zero_flag(z4), .sign_flag(s4), .carry_flag(c4), .dz_flag(d4));

  seq_alu_nbit #(.W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result_hi(hi16), .result_lo(lo16),
    .zero_flag(z16), .sign_flag(s16), .carry_flag(c16), .dz_flag(d16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo,
                              input logic z, input logic s, input logic c,
                              input logic d, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.z = z; e.s = s; e.c = c; e.d = d;
    e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  // Reference model built on the language's own arithmetic operators
  function automatic exp_t model(input int w, input logic [2:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
    longint unsigned m, xa, yb, p;
    exp_t e;
    m  = (64'd1 << w) - 64'd1;
    xa = {32'd0, x} & m;
    yb = {32'd0, y} & m;
    e  = mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    case (o)
      OP_ADD: begin
        p    = xa + yb;
        e.lo = 32'(p & m);
        e.c  = 1'((p >> w) & 64'd1);
      end
      OP_SUB: begin
        e.lo = 32'((xa - yb) & m);
        e.s  = (xa < yb);
        e.c  = (xa < yb);
      end
      OP_AND: e.lo = 32'(xa & yb);
      OP_MUL: begin
        p     = xa * yb;
        e.lo  = 32'(p & m);
        e.hi  = 32'((p >> w) & m);
        e.c   = (e.hi != 32'd0);
        e.lat = w + 1;
      end
      default: begin
        if (yb == 64'd0) begin
          e.lo = 32'(m);
          e.hi = 32'(xa);
          e.d  = 1'b1;
        end else begin
          e.lo  = 32'(xa / yb);
          e.hi  = 32'(xa % yb);
          e.lat = w + 1;
        end
      end
    endcase
    e.z = (e.hi == 32'd0) && (e.lo == 32'd0);
    return e;
  endfunction

  function automatic int qsize(input int w);
    case (w)
      8:       return q8.size();
      4:       return q4.size();
      default: return q16.size();
    endcase
  endfunction

  task automatic score(input string tag, input exp_t e, input logic [31:0] hi,
                       input logic [31:0] lo, input logic z, input logic s,
                       input logic c, input logic d);
    check({tag, "_hi"},   64'(hi), 64'(e.hi));
    check({tag, "_lo"},   64'(lo), 64'(e.lo));
    check({tag, "_zero"}, 64'(z),  64'(e.z));
    check({tag, "_sign"}, 64'(s),  64'(e.s));
    check({tag, "_carry"},64'(c),  64'(e.c));
    check({tag, "_dz"},   64'(d),  64'(e.d));
    check({tag, "_lat"},  64'(cyc - e.t0), 64'(e.lat));
  endtask

  task automatic unexpected(input string tag);
    tests++;
    fails++;
    $display("FAIL %s_unexpected_done: got done=1, required done=0 (t=%0t)", tag, $time);
  endtask

  // Monitors: pop the expected response whenever an instance signals done
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) unexpected("w8");
      else begin
        e = q8.pop_front();
        score("w8", e, 32'(hi8), 32'(lo8), z8, s8, c8, d8);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) unexpected("w4");
      else begin
        e = q4.pop_front();
        score("w4", e, 32'(hi4), 32'(lo4), z4, s4, c4, d4);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) unexpected("w16");
      else begin
        e = q16.pop_front();
        score("w16", e, 32'(hi16), 32'(lo16), z16, s16, c16, d16);
      end
    end
  end

  // Drive a one-cycle start pulse and optionally queue its expected response
  task automatic issue(input int w, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input exp_t e, input bit push);
    @(negedge clk);
    case (w)
      8:       begin start8  = 1'b1; op8  = o; a8  = x[7:0];  b8  = y[7:0];  end
      4:       begin start4  = 1'b1; op4  = o; a4  = x[3:0];  b4  = y[3:0];  end
      default: begin start16 = 1'b1; op16 = o; a16 = x[15:0]; b16 = y[15:0]; end
    endcase
    e.t0 = cyc;
    if (push) begin
      case (w)
        8:       q8.push_back(e);
        4:       q4.push_back(e);
        default: q16.push_back(e);
      endcase
    end
    @(negedge clk);
    start8  = 1'b0;
    start4  = 1'b0;
    start16 = 1'b0;
  endtask

  // Wait for all queued responses of one instance, bounded by a cycle budget
  task automatic drain(input int w, input int budget);
    for (int i = 0; i < budget && qsize(w) != 0; i++) @(negedge clk);
    if (qsize(w) != 0) begin
      tests++;
      fails++;
      $display("FAIL w%0d_drain_timeout: got %0d pending, required 0", w, qsize(w));
      case (w)
        8:       q8.delete();
        4:       q4.delete();
        default: q16.delete();
      endcase
    end
    @(negedge clk);
  endtask

  task automatic run_model(input int w, input logic [2:0] o,
                           input logic [31:0] x, input logic [31:0] y);
    issue(w, o, x, y, model(w, o, x, y), 1'b1);
    drain(w, w + 8);
  endtask

  task automatic random_pass(input int w);
    logic [2:0]  ops [6];
    logic [31:0] mx;
    ops = '{OP_MUL, OP_DIV, OP_MUL, OP_DIV, OP_ADD, OP_SUB};
    mx  = 32'((64'd1 << w) - 64'd1);
    run_model(w, OP_MUL, mx, mx);
    run_model(w, OP_DIV, mx, 32'd0);
    run_model(w, OP_DIV, 32'd1, mx);
    run_model(w, OP_DIV, mx, 32'd1);
    for (int i = 0; i < 12; i++)
      run_model(w, ops[$urandom_range(0, 5)],
                $urandom_range(0, int'(mx)), $urandom_range(1, int'(mx)));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset_n = 1'b0;
    start8 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    op8 = '0; op4 = '0; op16 = '0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0; a16 = '0; b16 = '0;

    #12;
    check("reset_busy_done", 64'({busy8, done8}), 64'd0);
    check("reset_results",   64'({hi8, lo8}),     64'd0);
    check("reset_flags",     64'({z8, s8, c8, d8}), 64'd0);

    @(negedge clk);
    reset_n = 1'b1;

    // ADD with carry-out
    issue(8, OP_ADD, 32'hF0, 32'h20, mk(32'h00, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    drain(8, 10);
    // SUB equal operands, then SUB with borrow
    issue(8, OP_SUB, 32'h05, 32'h05, mk(32'h00, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    drain(8, 10);
    issue(8, OP_SUB, 32'h03, 32'h07, mk(32'h00, 32'hFC, 1'b0, 1'b1, 1'b1, 1'b0, 1), 1'b1);
    drain(8, 10);
    // AND
    issue(8, OP_AND, 32'hC3, 32'h5A, mk(32'h00, 32'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    drain(8, 10);

    // Illegal op code is ignored
    issue(8, 3'b101, 32'h11, 32'h22, mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1), 1'b0);
    check("illegal_busy", 64'(busy8), 64'd0);
    repeat (3) @(negedge clk);
    check("illegal_busy_late", 64'(busy8), 64'd0);
    check("illegal_lo_held", 64'(lo8), 64'h42);

    // MUL 0xFF*0xFF with a start pulse at cycle 4 that must be ignored
    @(negedge clk);
    start8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF;
    begin
      exp_t e;
      e = mk(32'hFE, 32'h01, 1'b0, 1'b0, 1'b1, 1'b0, 9);
      e.t0 = cyc;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
    check("mul_busy", 64'(busy8), 64'd1);
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; op8 = OP_ADD; a8 = 8'h01; b8 = 8'h01;
    check("mul_partial_hidden", 64'({hi8, lo8}), 64'h0042);
    @(negedge clk);
    start8 = 1'b0;
    drain(8, 20);
    repeat (3) @(negedge clk);
    check("mul_idle_after", 64'(busy8), 64'd0);

    // DIV 200/7 then divide by zero
    issue(8, OP_DIV, 32'd200, 32'd7, mk(32'd4, 32'd28, 1'b0, 1'b0, 1'b0, 1'b0, 9), 1'b1);
    drain(8, 20);
    issue(8, OP_DIV, 32'h55, 32'h00, mk(32'h55, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1), 1'b1);
    drain(8, 10);
    // dz_flag clears on the next completion
    issue(8, OP_ADD, 32'h7F, 32'h01, mk(32'h00, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    drain(8, 10);

    // Reset mid-CALC aborts the MUL with no done
    issue(8, OP_MUL, 32'h12, 32'h34, mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 9), 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy_done", 64'({busy8, done8}), 64'd0);
    check("abort_results",   64'({hi8, lo8}),     64'd0);
    check("abort_flags",     64'({z8, s8, c8, d8}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_busy", 64'(busy8), 64'd0);
    issue(8, OP_ADD, 32'h01, 32'h01, mk(32'h00, 32'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    drain(8, 10);

    // Other widths against the reference model
    random_pass(4);
    random_pass(16);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu_nbit.md
SEQ_ALU_NBIT -- requirements
Module: seq_alu_nbit

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 4..32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 MUL, 100 DIV; other codes are illegal.
REQ-006 a  in  W  operand A (dividend, multiplicand, minuend); captured on accepted start.
REQ-007 b  in  W  operand B (divisor, multiplier, subtrahend); captured on accepted start.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse marking result valid.
REQ-010 result_hi  out  W  MUL product high half or DIV remainder; zero for ADD/SUB/AND.
REQ-011 result_lo  out  W  ADD/SUB/AND result, MUL product low half, or DIV quotient.
REQ-012 zero_flag, sign_flag, carry_flag, dz_flag  out  1 each  status of last completed operation.

Function
REQ-013 FSM states: IDLE, CALC, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-014 IDLE + start + legal op -> operands latched; ADD/SUB/AND/div-by-zero go to DONE, MUL/DIV go to CALC with step counter = W-1.
REQ-015 IDLE + start + illegal op -> ignored; no state change, no done.
REQ-016 start while busy or in DONE -> ignored; operands and op are not re-latched.
REQ-017 Latency: done pulses 1 cycle after start for ADD/SUB/AND/div-by-zero, W+1 cycles after start for MUL/DIV.
REQ-018 busy is high in CALC and DONE; low in IDLE.
REQ-019 ADD: result_lo = (a+b) mod 2^W; carry_flag = carry-out.
REQ-020 SUB: result_lo = (a-b) mod 2^W (two's-complement add); sign_flag = 1 iff a<b unsigned; carry_flag = borrow (same as sign_flag).
REQ-021 AND: result_lo = a & b; carry_flag = 0; sign_flag = 0.
REQ-022 MUL: unsigned shift-add, one multiplier bit per cycle LSB-first, {result_hi,result_lo} = a*b (2W bits); carry_flag = 1 iff result_hi != 0.
REQ-023 DIV: unsigned restoring division, one quotient bit per cycle MSB-first; result_lo = a/b, result_hi = a%b; carry_flag = 0.
REQ-024 DIV with b = 0: no CALC; result_lo = all ones, result_hi = a, dz_flag = 1; dz_flag = 0 for every other completion.
REQ-025 zero_flag = 1 iff {result_hi,result_lo} == 0 for the completed operation.
REQ-026 Results and flags update only in the cycle done is asserted; held stable until the next done.
REQ-027 Intermediate MUL/DIV partial values do not appear on result or flag outputs.

Reset
REQ-028 reset_n low: FSM -> IDLE, counter, operand registers, result_hi, result_lo, all flags, busy, done -> 0, asynchronously.
REQ-029 reset_n asserted mid-CALC aborts the operation; no done is produced for it.
REQ-030 First start is accepted on the first rising edge at which reset_n is high.

Structure
REQ-031 Shared package holds op encodings, FSM state encodings, and the W legal-range constant.
REQ-032 One sub-module, fadd_sub_nbit (parameter W, inputs a, b, sub; outputs sum, cout), is shared by ADD, SUB, MUL accumulate and DIV trial subtract.
REQ-033 A single W-bit step counter and one 2W-bit working register (hi:lo) serve both MUL and DIV.

Verification
REQ-034 W=8, ADD a=0xF0 b=0x20 -> done 1 cycle later; result_lo=0x10, carry_flag=1, zero_flag=0.
REQ-035 W=8, SUB a=0x05 b=0x05 -> result_lo=0x00, zero_flag=1, sign_flag=0; then SUB a=0x03 b=0x07 -> result_lo=0xFC, sign_flag=1, carry_flag=1.
REQ-036 W=8, MUL a=0xFF b=0xFF -> done exactly 9 cycles after start; result_hi=0xFE, result_lo=0x01, carry_flag=1; start pulsed at cycle 4 is ignored.
REQ-037 W=8, DIV a=200 b=7 -> done 9 cycles after start; result_lo=28, result_hi=4; then DIV a=0x55 b=0 -> done 1 cycle later, result_lo=0xFF, result_hi=0x55, dz_flag=1.
REQ-038 W=8, MUL started, reset_n pulsed low at cycle 3 -> all outputs 0 immediately, no done; next ADD a=1 b=1 -> result_lo=0x02.
REQ-039 W=4 and W=16 rerun of REQ-036/REQ-037 with random operands against a reference model -> all results and flags match; MUL/DIV latency = W+1.
